sel_decoder_seq: RTL



---
 rtl/sel_decoder_seq_if.sv | 40 ++++
 rtl/sel_decoder_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sel_decoder_seq_if.sv
// Request/select bundle between the control unit and the register-select decoder.
// The control unit takes the master modport and the decoder takes the slave modport.
interface sel_decoder_seq_if #(
    parameter int AW    = 4,
    parameter int OUT_W = 16
);
    logic             req_valid;
    logic [AW-1:0]    req_addr;
    logic             req_ready;
    logic             clr;
    logic             sweep_start;
    logic             sweep_busy;
    logic [OUT_W-1:0] sel;
    logic             sel_valid;
    logic             addr_err;

    modport master (
        output req_valid,
        output req_addr,
        output clr,
        output sweep_start,
        input  req_ready,
        input  sweep_busy,
        input  sel,
        input  sel_valid,
        input  addr_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  clr,
        input  sweep_start,
        output req_ready,
        output sweep_busy,
        output sel,
        output sel_valid,
        output addr_err
    );
endinterface

// File: rtl/sel_decoder_seq.sv
// Registered one-hot register-select decoder with level/pulse modes and a boot-clear sweep.
// Latency 1 cycle from accept to sel; req_ready drops while sweeping or when clr/sweep_start is high.
// Optional sticky one-hot checker enabled by SEL_DECODER_ONEHOT_CHECK_EN (adds port sel_err).
module sel_decoder_seq #(
    parameter int AW    = 4,
    parameter int OUT_W = 16,
    parameter bit PULSE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    sel_decoder_seq_if.slave bus
`ifdef SEL_DECODER_ONEHOT_CHECK_EN
    ,
    output logic             sel_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(OUT_W - 1);

    state_t           state_q, state_d;
    logic [OUT_W-1:0] sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             addr_err_q, addr_err_d;
    logic [AW-1:0]    cnt_q, cnt_d;

    logic             req_ready;
    logic             accept;
    logic             addr_legal;

    function automatic logic [OUT_W-1:0] onehot(input logic [AW-1:0] idx);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (idx == AW'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    assign req_ready  = (state_q != SWEEP) && !bus.sweep_start && !bus.clr;
    assign accept     = bus.req_valid && req_ready;
    // Extra MSB keeps the compare meaningful when OUT_W == 2**AW.
    assign addr_legal = ({1'b0, bus.req_addr} < (AW + 1)'(OUT_W));

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        addr_err_d = 1'b0;

        if (state_q == SWEEP) begin
            if (bus.clr || (cnt_q == LAST_IDX)) begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + AW'(1);
                sel_d = onehot(cnt_q + AW'(1));
            end
        end else if (bus.clr) begin
            state_d = IDLE;
            sel_d   = '0;
        end else if (bus.sweep_start) begin
            state_d = SWEEP;
            cnt_d   = '0;
            sel_d   = onehot('0);
        end else if (accept) begin
            if (addr_legal) begin
                sel_d   = onehot(bus.req_addr);
                state_d = PULSE ? IDLE : HOLD;
            end else begin
                sel_d      = '0;
                addr_err_d = 1'b1;
                state_d    = IDLE;
            end
        end else if (PULSE) begin
            // Pulse mode never holds: an unrefreshed select lasts one cycle.
            sel_d   = '0;
            state_d = IDLE;
        end

        sel_valid_d = |sel_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            addr_err_q  <= addr_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.sweep_busy = (state_q == SWEEP);
    assign bus.sel        = sel_q;
    assign bus.sel_valid  = sel_valid_q;
    assign bus.addr_err   = addr_err_q;

`ifdef SEL_DECODER_ONEHOT_CHECK_EN
    logic sel_err_q, sel_err_d;
    logic sel_multi;

    // x & (x-1) is non-zero exactly when more than one bit is set.
    assign sel_multi = |(sel_q & (sel_q - OUT_W'(1)));

    always_comb begin
        sel_err_d = sel_err_q | sel_multi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
            assert (!sel_multi) else $error("sel has more than one bit set: %h", sel_q);
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule
